whack_game_core: RTL and testbench

WHACK_GAME_CORE -- requirements
Module: whack_game_core

---
 rtl/whack_pkg.sv | 39 +++
 rtl/mole_lfsr.sv | 37 +++
 rtl/whack_game_core.sv | 203 ++++++++++++++++++++
 tb/tb_whack_game_core.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game core.
//   state_e    : top-level game state (IDLE, PLAY, OVER)
//   LFSR_SEED  : non-zero reset value for the mole LFSR; narrower LFSRs
//                take its low bits
//   lfsr_taps  : Galois feedback mask giving a maximal-length sequence
//                for a register of the given width (2..16)
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_SEED = {8'hA5, 8'hA5};

    // Masks for a right-shifting Galois LFSR; bit k set means the output
    // bit is XORed into position k on every shift.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            2:       return 16'h0003;
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0E08;
            13:      return 16'h1C80;
            14:      return 16'h3802;
            15:      return 16'h6000;
            default: return 16'hB400;
        endcase
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running maximal-length Galois LFSR used to pick mole masks.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset, loads the seed
//   value_o : current LFSR state (never zero)
module mole_lfsr
    import whack_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [WIDTH-1:0] value_o
);

    localparam logic [15:0]      TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED      = LFSR_SEED[WIDTH-1:0];

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = {1'b0, state_q[WIDTH-1:1]} ^ (state_q[0] ? TAPS : '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign value_o = state_q;

endmodule

// File: rtl/whack_game_core.sv
// Whack-a-mole game core. A random mask of holes is lit for LIFE_TICKS game
// ticks; the player flips switches under lit holes to score. Unwhacked moles
// at mask expiry are counted as misses. A game is ROUNDS masks long.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   start     : one-cycle pulse, starts a game from IDLE or OVER
//   DPSwitch  : raw asynchronous player switches, any flip counts as a whack
//   LED       : lit-mole mask
//   score     : saturating score
//   misses    : saturating count of moles that expired unwhacked
//   hit       : one-cycle pulse, at least one mole whacked
//   game_over : high while the game is finished
module whack_game_core
    import whack_pkg::*;
#(
    parameter int N_HOLES    = 8,
    parameter int SCORE_W    = 8,
    parameter int TICK_DIV   = 50_000_000,
    parameter int LIFE_TICKS = 3,
    parameter int ROUNDS     = 32,
    parameter int PENALTY_EN = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_HOLES-1:0] DPSwitch,
    output logic [N_HOLES-1:0] LED,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic               hit,
    output logic               game_over
);

    localparam int LFSR_W  = (N_HOLES <= 8) ? 8 : 16;
    localparam int TDIV_W  = $clog2(TICK_DIV);
    localparam int LIFE_W  = $clog2(LIFE_TICKS + 1);
    localparam int ROUND_W = $clog2(ROUNDS + 1);

    localparam logic [TDIV_W-1:0]  TICK_LAST  = TDIV_W'(TICK_DIV - 1);
    localparam logic [LIFE_W-1:0]  LIFE_LAST  = LIFE_W'(LIFE_TICKS - 1);
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS - 1);

    function automatic logic [4:0] popcount(input logic [N_HOLES-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < N_HOLES; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [4:0]         b);
        logic [SCORE_W+5:0] s;
        s = (SCORE_W + 6)'(a) + (SCORE_W + 6)'(b);
        if (s > (SCORE_W + 6)'({SCORE_W{1'b1}})) begin
            return '1;
        end
        return s[SCORE_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] a,
                                                   input logic [4:0]         b);
        if ((SCORE_W + 6)'(b) > (SCORE_W + 6)'(a)) begin
            return '0;
        end
        // b <= a here, so narrowing b cannot lose bits.
        return a - SCORE_W'(b);
    endfunction

    // An all-zero draw would give the player nothing to hit.
    function automatic logic [N_HOLES-1:0] mask_of(input logic [LFSR_W-1:0] v);
        logic [N_HOLES-1:0] m;
        m = v[N_HOLES-1:0];
        if (m == '0) begin
            m = N_HOLES'(1);
        end
        return m;
    endfunction

    logic [LFSR_W-1:0]  lfsr_val;

    logic [N_HOLES-1:0] sync1_q, sync2_q, prev_q;
    logic [N_HOLES-1:0] toggle;
    logic [4:0]         hits, wrong;

    state_e             state_q, state_d;
    logic [TDIV_W-1:0]  tdiv_q, tdiv_d;
    logic [LIFE_W-1:0]  life_q, life_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [N_HOLES-1:0] led_q, led_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] misses_q, misses_d;
    logic               hit_q, hit_d;
    logic               tick;

    mole_lfsr #(
        .WIDTH(LFSR_W)
    ) u_lfsr (
        .clk_i  (clk),
        .rst_ni (rst),
        .value_o(lfsr_val)
    );

    // Either switch direction is a whack.
    assign toggle = sync2_q ^ prev_q;
    assign hits   = popcount(toggle & led_q);
    assign wrong  = popcount(toggle & ~led_q);

    always_comb begin
        state_d  = state_q;
        tdiv_d   = tdiv_q;
        life_d   = life_q;
        round_d  = round_q;
        led_d    = led_q;
        score_d  = score_q;
        misses_d = misses_q;
        hit_d    = 1'b0;
        tick     = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                led_d = '0;
                if (start) begin
                    state_d  = PLAY;
                    tdiv_d   = '0;
                    life_d   = '0;
                    round_d  = '0;
                    score_d  = '0;
                    misses_d = '0;
                    led_d    = mask_of(lfsr_val);
                end
            end
            PLAY: begin
                tick    = (tdiv_q == TICK_LAST);
                tdiv_d  = tick ? '0 : tdiv_q + 1'b1;
                hit_d   = (hits != 5'd0);
                score_d = sat_add(score_q, hits);
                if (PENALTY_EN != 0) begin
                    score_d = sat_sub(score_d, wrong);
                end
                led_d = led_q & ~toggle;
                // life_q counts ticks already spent by the current mask.
                if (tick) begin
                    if (life_q == LIFE_LAST) begin
                        life_d = '0;
                        // Moles whacked in the expiry cycle already scored.
                        misses_d = sat_add(misses_q, popcount(led_q & ~toggle));
                        if (round_q == ROUND_LAST) begin
                            state_d = OVER;
                            led_d   = '0;
                        end else begin
                            round_d = round_q + 1'b1;
                            led_d   = mask_of(lfsr_val);
                        end
                    end else begin
                        life_d = life_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                led_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            state_q  <= IDLE;
            tdiv_q   <= '0;
            life_q   <= '0;
            round_q  <= '0;
            led_q    <= '0;
            score_q  <= '0;
            misses_q <= '0;
            hit_q    <= 1'b0;
        end else begin
            sync1_q  <= DPSwitch;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            state_q  <= state_d;
            tdiv_q   <= tdiv_d;
            life_q   <= life_d;
            round_q  <= round_d;
            led_q    <= led_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            hit_q    <= hit_d;
        end
    end

    assign LED       = led_q;
    assign score     = score_q;
    assign misses    = misses_q;
    assign hit       = hit_q;
    assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_whack_game_core.sv
// Directed bench for whack_game_core. Three instances share clock, reset
// and therefore LFSR sequence: A (no penalty), B (penalty), C (2-bit score).
// A reference LFSR tells the bench which mask a start pulse will load, so
// starts are timed to obtain the wanted masks.
module tb_whack_game_core;

    logic       clk;
    logic       rst;
    logic       start_a, start_b, start_c;
    logic [7:0] dsw_a, dsw_b, dsw_c;
    logic [7:0] led_a, led_b, led_c;
    logic [7:0] score_a, misses_a, score_b, misses_b;
    logic [1:0] score_c, misses_c;
    logic       hit_a, hit_b, hit_c;
    logic       go_a, go_b, go_c;

    int checks   = 0;
    int failures = 0;

    logic [7:0] lfsr_m;
    logic [7:0] m2, m3;
    logic       found;

    whack_game_core #(.N_HOLES(8), .SCORE_W(8), .TICK_DIV(4), .LIFE_TICKS(2),
                      .ROUNDS(3), .PENALTY_EN(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .DPSwitch(dsw_a), .LED(led_a),
        .score(score_a), .misses(misses_a), .hit(hit_a), .game_over(go_a));

    whack_game_core #(.N_HOLES(8), .SCORE_W(8), .TICK_DIV(4), .LIFE_TICKS(2),
                      .ROUNDS(3), .PENALTY_EN(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .DPSwitch(dsw_b), .LED(led_b),
        .score(score_b), .misses(misses_b), .hit(hit_b), .game_over(go_b));

    whack_game_core #(.N_HOLES(8), .SCORE_W(2), .TICK_DIV(4), .LIFE_TICKS(2),
                      .ROUNDS(3), .PENALTY_EN(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .DPSwitch(dsw_c), .LED(led_c),
        .score(score_c), .misses(misses_c), .hit(hit_c), .game_over(go_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 8-bit Galois LFSR, polynomial mask 0xB8, seed 0xA5.
    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr_m <= 8'hA5;
        else      lfsr_m <= {1'b0, lfsr_m[7:1]} ^ (lfsr_m[0] ? 8'hB8 : 8'h00);
    end

    function automatic logic [7:0] mask_of(input logic [7:0] v);
        return (v == 8'h00) ? 8'h01 : v;
    endfunction

    function automatic int pop8(input logic [7:0] v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge whose following posedge will load the target.
    task automatic wait_mask(input logic [7:0] target, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (mask_of(lfsr_m) == target) ok = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        dsw_a = 8'h00; dsw_b = 8'h00; dsw_c = 8'h00;
        #1 rst = 1'b0;
        #2;
        check("rst_led",    16'(led_a),    16'h0);
        check("rst_score",  16'(score_a),  16'h0);
        check("rst_misses", 16'(misses_a), 16'h0);
        check("rst_hit",    16'(hit_a),    16'h0);
        check("rst_go",     16'(go_a),     16'h0);
        @(negedge clk);
        #2 rst = 1'b1;

        // ---- A, game 1: mask 0x81, whack both moles in one cycle ----
        wait_mask(8'h81, found);
        check("a_find81", 16'(found), 16'h1);
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        check("a1_led0",   16'(led_a),    16'h81);
        check("a1_score0", 16'(score_a),  16'h0);
        check("a1_go0",    16'(go_a),     16'h0);
        check("a1_hit0",   16'(hit_a),    16'h0);
        dsw_a = 8'h81;
        cyc(2);
        check("a1_nohit_yet", 16'(hit_a),   16'h0);
        check("a1_led_held",  16'(led_a),   16'h81);
        cyc(1);
        check("a1_score2", 16'(score_a), 16'h2);
        check("a1_hit",    16'(hit_a),   16'h1);
        check("a1_led_clr", 16'(led_a),  16'h00);
        cyc(1);
        check("a1_hit_pulse", 16'(hit_a), 16'h0);
        cyc(3);
        m2 = mask_of(lfsr_m);
        check("a1_miss_r1", 16'(misses_a), 16'h0);
        cyc(1);
        check("a1_led_r2",  16'(led_a),    16'(m2));
        check("a1_miss_r1b", 16'(misses_a), 16'h0);
        cyc(7);
        m3 = mask_of(lfsr_m);
        cyc(1);
        check("a1_led_r3",  16'(led_a),    16'(m3));
        check("a1_miss_r2", 16'(misses_a), 16'(pop8(m2)));
        cyc(7);
        check("a1_go_early", 16'(go_a), 16'h0);
        cyc(1);
        check("a1_go",       16'(go_a),     16'h1);
        check("a1_go_led",   16'(led_a),    16'h0);
        check("a1_go_miss",  16'(misses_a), 16'(pop8(m2) + pop8(m3)));
        check("a1_go_score", 16'(score_a),  16'h2);
        // Toggles while OVER must not score.
        dsw_a = 8'h7E;
        cyc(5);
        check("a1_over_score", 16'(score_a),  16'h2);
        check("a1_over_hit",   16'(hit_a),    16'h0);
        check("a1_over_led",   16'(led_a),    16'h0);
        check("a1_over_miss",  16'(misses_a), 16'(pop8(m2) + pop8(m3)));

        // ---- A, game 2: restart from OVER with mask 0x0F, let it expire ----
        wait_mask(8'h0F, found);
        check("a_find0f", 16'(found), 16'h1);
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        check("a2_led0",   16'(led_a),    16'h0F);
        check("a2_score0", 16'(score_a),  16'h0);
        check("a2_miss0",  16'(misses_a), 16'h0);
        check("a2_go0",    16'(go_a),     16'h0);
        cyc(2);
        start_a = 1'b1;      // ignored while playing
        cyc(1);
        start_a = 1'b0;
        cyc(4);
        m2 = mask_of(lfsr_m);
        check("a2_led_r1", 16'(led_a),    16'h0F);
        check("a2_miss_r1", 16'(misses_a), 16'h0);
        cyc(1);
        check("a2_miss4",  16'(misses_a), 16'h4);
        check("a2_led_r2", 16'(led_a),    16'(m2));
        dsw_a = dsw_a ^ m2;
        cyc(3);
        check("a2_score_r2", 16'(score_a), 16'(pop8(m2)));
        check("a2_hit_r2",   16'(hit_a),   16'h1);
        check("a2_led_clr",  16'(led_a),   16'h0);

        // ---- Asynchronous reset in the middle of play ----
        cyc(1);
        #2 rst = 1'b0;
        #1;
        check("mrst_led",    16'(led_a),    16'h0);
        check("mrst_score",  16'(score_a),  16'h0);
        check("mrst_misses", 16'(misses_a), 16'h0);
        check("mrst_hit",    16'(hit_a),    16'h0);
        check("mrst_go",     16'(go_a),     16'h0);
        check("mrst_b", 16'({led_b, score_b} | {misses_b, 6'h0, hit_b, go_b}), 16'h0);
        check("mrst_c", 16'({led_c, score_c, misses_c, hit_c, go_c}), 16'h0);
        #1 rst = 1'b1;
        cyc(4);
        check("post_rst_led",   16'(led_a),    16'h0);
        check("post_rst_score", 16'(score_a),  16'h0);
        check("post_rst_miss",  16'(misses_a), 16'h0);
        check("post_rst_go",    16'(go_a),     16'h0);

        // ---- B: penalty scoring on mask 0x0F ----
        wait_mask(8'h0F, found);
        check("b_find0f", 16'(found), 16'h1);
        start_b = 1'b1;
        cyc(1);
        start_b = 1'b0;
        check("b_led0", 16'(led_b), 16'h0F);
        dsw_b = 8'h80;       // unlit hole with score 0
        cyc(1);
        dsw_b = 8'h87;       // three lit holes
        cyc(1);
        dsw_b = 8'hBF;       // two unlit + one lit
        cyc(1);
        check("b_wrong_at0",  16'(score_b), 16'h0);
        check("b_wrong_nohit", 16'(hit_b),  16'h0);
        check("b_led_keep",   16'(led_b),   16'h0F);
        cyc(1);
        check("b_score3", 16'(score_b), 16'h3);
        check("b_hit3",   16'(hit_b),   16'h1);
        check("b_led08",  16'(led_b),   16'h08);
        cyc(1);
        check("b_score2", 16'(score_b), 16'h2);
        check("b_hit1",   16'(hit_b),   16'h1);
        check("b_led00",  16'(led_b),   16'h00);

        // ---- C: 2-bit score saturates at 3 ----
        wait_mask(8'h1F, found);
        check("c_find1f", 16'(found), 16'h1);
        start_c = 1'b1;
        cyc(1);
        start_c = 1'b0;
        check("c_led0", 16'(led_c), 16'h1F);
        dsw_c = 8'h03;
        cyc(1);
        dsw_c = 8'h1F;
        cyc(2);
        check("c_score2", 16'(score_c), 16'h2);
        check("c_led1c",  16'(led_c),   16'h1C);
        cyc(1);
        check("c_sat",    16'(score_c), 16'h3);
        check("c_hit",    16'(hit_c),   16'h1);
        check("c_led00",  16'(led_c),   16'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
